// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared convolutional code parameters and framer state encoding
package viterbi_pkg;

    localparam int K_DEF = 3;
    localparam int M_DEF = K_DEF - 1;
    localparam logic [K_DEF-1:0] G0_DEF = 3'b111;
    localparam logic [K_DEF-1:0] G1_DEF = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        ENC,
        TAIL,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/conv_enc_core.sv
// rtl/conv_enc_core.sv - combinational rate-1/2 generator: symbol and next shift state
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter int K = K_DEF,
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic [K-2:0] st,
    input  logic         b,
    output logic [1:0]   sym,
    output logic [K-2:0] st_next
);

    logic [K-1:0] r;

    // Newest bit sits at the LSB of the register window.
    assign r       = {st, b};
    assign sym     = {^(r & G0), ^(r & G1)};
    assign st_next = {st[K-3:0], b};

endmodule

// File: rtl/conv_enc_framer.sv
// rtl/conv_enc_framer.sv - framed convolutional encoder with optional zero tail
module conv_enc_framer
    import viterbi_pkg::*;
#(
    parameter int K = K_DEF,
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic       tail_en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [1:0] sym_out,
    output logic [7:0] sym_idx,
    output logic [7:0] out_len,
    output logic       busy,
    output logic       done
);

    localparam int M = K - 1;

    state_t       state, state_next;
    logic [M-1:0] st, st_next;
    logic [7:0]   frame_len_q;
    logic         tail_en_q;
    logic [7:0]   bit_cnt;
    logic [7:0]   tail_cnt;
    logic [7:0]   idx_next;
    logic         out_free;
    logic         xfer;
    logic         load;
    logic         enc_bit;
    logic [1:0]   sym;

    assign out_free = !sym_valid || sym_ready;
    assign xfer     = in_valid && in_ready;
    assign load     = xfer || ((state == TAIL) && out_free);
    assign enc_bit  = (state == ENC) ? in_bit : 1'b0;

    conv_enc_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .st      (st),
        .b       (enc_bit),
        .sym     (sym),
        .st_next (st_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (frame_len != 8'd0) begin
                        state_next = ENC;
                    end else begin
                        state_next = tail_en ? TAIL : FLUSH;
                    end
                end
            end
            ENC: begin
                if (xfer && (bit_cnt == frame_len_q - 8'd1)) begin
                    state_next = tail_en_q ? TAIL : FLUSH;
                end
            end
            TAIL: begin
                if (out_free && (tail_cnt == 8'(M - 1))) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        in_ready = (state == ENC) && out_free;
    end

    // A load always wins over an acceptance, so back-to-back symbols keep sym_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= '0;
            frame_len_q <= 8'd0;
            tail_en_q   <= 1'b0;
            out_len     <= 8'd0;
            bit_cnt     <= 8'd0;
            tail_cnt    <= 8'd0;
            idx_next    <= 8'd0;
            sym_valid   <= 1'b0;
            sym_out     <= 2'b00;
            sym_idx     <= 8'd0;
        end else begin
            if ((state == IDLE) && start) begin
                frame_len_q <= frame_len;
                tail_en_q   <= tail_en;
                st          <= '0;
                out_len     <= frame_len + (tail_en ? 8'(M) : 8'd0);
                bit_cnt     <= 8'd0;
                tail_cnt    <= 8'd0;
                idx_next    <= 8'd0;
            end
            if (load) begin
                st        <= st_next;
                sym_out   <= sym;
                sym_idx   <= idx_next;
                idx_next  <= idx_next + 8'd1;
                sym_valid <= 1'b1;
                if (state == ENC) begin
                    bit_cnt <= bit_cnt + 8'd1;
                end else begin
                    tail_cnt <= tail_cnt + 8'd1;
                end
            end else if (sym_ready) begin
                sym_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_enc_framer.sv
// tb/tb_conv_enc_framer.sv - scoreboard bench for conv_enc_framer
module tb_conv_enc_framer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] frame_len = 8'd0;
    logic       tail_en = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       sym_ready = 1'b1;
    logic       in_ready;
    logic       sym_valid;
    logic [1:0] sym_out;
    logic [7:0] sym_idx;
    logic [7:0] out_len;
    logic       busy;
    logic       done;

    int         tests = 0;
    int         errors = 0;
    logic [9:0] exp_q[$];
    logic [1:0] rx_syms [0:299];
    int         rx_cnt = 0;
    bit         mon_en = 1'b0;
    logic [1:0] ms;
    logic [7:0] m_idx;
    logic [9:0] mon_e;
    logic [1:0] ref034 [0:5] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11};

    conv_enc_framer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .frame_len (frame_len),
        .tail_en   (tail_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_out   (sym_out),
        .sym_idx   (sym_idx),
        .out_len   (out_len),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-expanded 111/101 code: ms[0] is the newest stored bit, ms[1] the oldest.
    task automatic model_push(input logic b);
        logic [1:0] s;
        s = {b ^ ms[0] ^ ms[1], b ^ ms[1]};
        exp_q.push_back({m_idx, s});
        m_idx = m_idx + 8'd1;
        ms = {ms[0], b};
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n && sym_valid && sym_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sym_unexpected", 32'(sym_idx), 32'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("sym_idx", 32'(sym_idx), 32'(mon_e[9:2]));
                check_eq("sym_out", 32'(sym_out), 32'(mon_e[1:0]));
            end
            if (rx_cnt < 300) rx_syms[rx_cnt] = sym_out;
            rx_cnt++;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_outs"},
                 32'({sym_valid, sym_out, sym_idx, out_len, busy, done, in_ready}), 32'd0);
        check_eq({tag, "_st"}, 32'(dut.st), 32'd0);
    endtask

    task automatic run_frame(input int len, input bit tail, input logic [255:0] bits,
                             input bit poke, input int exp_lat);
        time t_s;
        time tn;
        bit  got;
        int  exp_len;
        exp_len = (len + (tail ? 2 : 0)) % 256;
        ms = 2'b00;
        m_idx = 8'd0;
        rx_cnt = 0;
        @(posedge clk);
        t_s = $time;
        #1;
        frame_len = len[7:0];
        tail_en = tail;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_bit = bits[i];
            if (poke && i == 3) begin
                start = 1'b1;
                frame_len = 8'd3;
                tail_en = ~tail;
            end
            got = 1'b0;
            for (int w = 0; w < 50 && !got; w++) begin
                @(negedge clk);
                if (in_ready) begin
                    model_push(bits[i]);
                    got = 1'b1;
                end
                @(posedge clk);
                #1;
            end
            if (!got) check_eq("in_ready_timeout", 32'd0, 32'd1);
            start = 1'b0;
            frame_len = len[7:0];
            tail_en = tail;
        end
        in_valid = 1'b0;
        if (tail) begin
            model_push(1'b0);
            model_push(1'b0);
        end
        got = 1'b0;
        for (int w = 0; w < 300 && !got; w++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check_eq("done_seen", 32'(got), 32'd1);
        tn = $time;
        if (exp_lat > 0) check_eq("done_latency", 32'((tn - 5 - t_s) / 10), 32'(exp_lat));
        check_eq("out_len", 32'(out_len), 32'(exp_len));
        if (tail) check_eq("st_at_done", 32'(dut.st), 32'd0);
        check_eq("rx_count", 32'(rx_cnt), 32'(len + (tail ? 2 : 0)));
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check_eq("done_one_cycle", 32'({done, busy}), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic stall_task;
        logic [1:0] hs;
        logic [7:0] hi;
        bit         got;
        got = 1'b0;
        for (int w = 0; w < 300 && !got; w++) begin
            @(negedge clk);
            if (sym_valid && sym_idx == 8'd4) got = 1'b1;
        end
        check_eq("stall_reach", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        sym_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                hs = sym_out;
                hi = sym_idx;
                check_eq("stall_idx", 32'(hi), 32'd5);
            end
            check_eq("stall_sym_hold", 32'(sym_out), 32'(hs));
            check_eq("stall_idx_hold", 32'(sym_idx), 32'(hi));
            check_eq("stall_valid", 32'(sym_valid), 32'd1);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        sym_ready = 1'b1;
    endtask

    initial begin
        logic [255:0] bits;
        int           nz;
        bit           got;

        #3;
        check_outputs_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        bits = '0;
        bits[8] = 1'b1;
        run_frame(32, 1'b0, bits, 1'b0, 0);
        nz = 0;
        for (int i = 0; i < 32; i++) begin
            if ((i < 8 || i > 10) && rx_syms[i] != 2'b00) nz++;
        end
        check_eq("impulse_zeros", 32'(nz), 32'd0);
        check_eq("impulse_s8", 32'(rx_syms[8]), 32'd3);
        check_eq("impulse_s9", 32'(rx_syms[9]), 32'd2);
        check_eq("impulse_s10", 32'(rx_syms[10]), 32'd3);

        bits = 256'hF;
        run_frame(4, 1'b1, bits, 1'b0, 0);
        for (int i = 0; i < 6; i++) check_eq("ones_tail_sym", 32'(rx_syms[i]), 32'(ref034[i]));

        for (int i = 0; i < 8; i++) bits[i*32 +: 32] = $urandom;
        fork
            run_frame(16, 1'b1, bits, 1'b0, 0);
            stall_task();
        join

        run_frame(0, 1'b0, '0, 1'b0, 2);
        run_frame(0, 1'b1, '0, 1'b0, 0);
        check_eq("empty_tail_s0", 32'(rx_syms[0]), 32'd0);
        check_eq("empty_tail_s1", 32'(rx_syms[1]), 32'd0);

        bits = 256'hC3;
        run_frame(8, 1'b0, bits, 1'b1, 0);

        mon_en = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        frame_len = 8'd32;
        tail_en = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_valid = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 200 && !got; w++) begin
            @(negedge clk);
            in_bit = 1'($urandom);
            if (sym_valid && sym_idx == 8'd10) got = 1'b1;
        end
        check_eq("reset_reach", 32'(got), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("held_reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        bits = 256'h0A5B;
        run_frame(12, 1'b1, bits, 1'b0, 0);

        for (int i = 0; i < 8; i++) bits[i*32 +: 32] = $urandom;
        run_frame(40, 1'b1, bits, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/conv_enc_framer.md
CONV_ENC_FRAMER -- requirements
Module: conv_enc_framer

Interface
REQ-001 SHALL have parameter K, default 3, constraint length; M = K-1 memory bits, 2**M trellis states.
REQ-002 SHALL have parameter G0, default 3'b111 (K bits), generator polynomial for sym_out[1].
REQ-003 SHALL have parameter G1, default 3'b101 (K bits), generator polynomial for sym_out[0].
REQ-004 SHALL have port clk, input, 1 bit, single rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit, begins a frame; ignored unless state is IDLE.
REQ-007 SHALL have port frame_len, input, 8 bits, count of data bits in the frame, sampled on start.
REQ-008 SHALL have port tail_en, input, 1 bit, append M zero tail bits, sampled on start.
REQ-009 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_bit (input, 1), forming the data-bit handshake.
REQ-010 SHALL have ports sym_valid (output, 1), sym_ready (input, 1) and sym_out (output, 2), forming the encoded-symbol handshake.
REQ-011 SHALL have port sym_idx, output, 8 bits, frame index of the symbol currently on sym_out.
REQ-012 SHALL have port out_len, output, 8 bits, total number of symbols in the frame.
REQ-013 SHALL have ports busy (output, 1) and done (output, 1).

Function
REQ-014 SHALL implement FSM IDLE -> ENC -> TAIL -> FLUSH -> DONE -> IDLE.
REQ-015 SHALL, on start in IDLE, latch frame_len and tail_en, clear the shift register st, set out_len = frame_len + (tail_en ? M : 0) mod 256, and go to ENC.
REQ-016 SHALL, when the latched frame_len is 0, skip ENC and go to TAIL if tail_en is set, otherwise to FLUSH.
REQ-017 SHALL drive in_ready = (state==ENC) && (!sym_valid || sym_ready), combinationally.
REQ-018 SHALL form r = {st, b} for each encoded bit b, and compute sym = {^(r&G0), ^(r&G1)}.
REQ-019 SHALL update the shift register as st <= {st[M-2:0], b}, inserting at the LSB.
REQ-020 SHALL sample in_bit only on an in_valid && in_ready transfer, and register sym on the next edge (1-cycle latency) with sym_valid set.
REQ-021 SHALL hold sym_out and sym_idx stable while sym_valid && !sym_ready.
REQ-022 SHALL clear sym_valid after a sym_ready acceptance unless a new symbol loads on the same edge.
REQ-023 SHALL advance from ENC after the frame_len-th transfer, to TAIL if tail_en is set, else to FLUSH.
REQ-024 SHALL, in TAIL, encode M internal zero bits under the same output-register rule with no input handshake, then go to FLUSH.
REQ-025 SHALL leave FLUSH only when the output register is empty or being accepted, then go to DONE.
REQ-026 SHALL assert done for exactly one cycle, in DONE; st SHALL be 0 there whenever tail_en was set.
REQ-027 SHALL drive busy high in every state except IDLE.
REQ-028 SHALL increment sym_idx by 1 per emitted symbol, starting at 0, with 8-bit wrap.

Reset
REQ-029 SHALL, while rst_n is low (including mid-frame), immediately force state to IDLE, st to 0, and sym_valid, sym_out, sym_idx, out_len, busy and done to 0, and in_ready to 0.
REQ-030 SHALL NOT emit a partial frame after rst_n is released; the frame is discarded.

Structure
REQ-031 SHALL place K, M, G0 and G1 defaults and the FSM state enum in a shared package, viterbi_pkg, also used by the decoder.
REQ-032 SHALL isolate the generator function in sub-module conv_enc_core: combinational, inputs st and b, outputs sym and next st.

Verification
REQ-033 SHALL cover: frame_len=32, impulse at bit 8, tail_en=0, sym_ready=1 -> symbols 8/9/10 = 11/10/11, all others 00, done 1 cycle.
REQ-034 SHALL cover: frame_len=4, bits 1111, tail_en=1 -> out_len=6, symbols 11,01,10,10,01,11, st=0 at done.
REQ-035 SHALL cover: sym_ready low for 5 cycles mid-frame -> sym_out/sym_idx stable, in_ready=0, no lost or duplicated symbols.
REQ-036 SHALL cover: frame_len=0, tail_en=0 -> done 2 cycles after start, no sym_valid; with tail_en=1 -> exactly 2 symbols 00.
REQ-037 SHALL cover: rst_n low at symbol 10 of 32 -> all outputs 0 asynchronously; new start then encodes cleanly from st=0.
REQ-038 SHALL cover: start pulsed during ENC -> ignored, frame_len/out_len unchanged.
